// File: rtl/pip_reg.sv
// Pipeline boundary register: one-cycle data/valid stage with stall, flush
// (bubble insert) and synchronous active-low reset. Reset has the highest
// priority, then flush, then stall; otherwise the stage loads.
module pip_reg #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             out_valid
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_d;
  logic             out_valid_q;

  // Next-state selection below reset: flush beats stall, stall beats load.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_d       = RESET_VALUE;
      out_valid_d = 1'b0;
    end else if (en) begin
      out_d       = in;
      out_valid_d = in_valid;
    end
  end

  // Stage flops with synchronous reset overriding every other control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= RESET_VALUE;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pip_reg.sv
// Self-checking bench for pip_reg: a 32-bit default instance and an 8-bit
// instance with a non-zero reset value share the same controls.
module tb_pip_reg;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [31:0] in32;
  logic [31:0] out32;
  logic        ov32;
  logic [7:0]  in8;
  logic [7:0]  out8;
  logic        ov8;

  int n_cmp = 0;
  int n_bad = 0;

  pip_reg u_dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in32),
    .out      (out32),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .out_valid(ov32)
  );

  pip_reg #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in8),
    .out      (out8),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .out_valid(ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what each stage holds after an edge, from the priority rules.
  typedef struct {
    logic [31:0] data;
    logic        valid;
  } slot_t;

  slot_t exp32;
  slot_t exp8;
  bit    known = 1'b0;

  function automatic slot_t next_slot(slot_t cur, logic [31:0] d, logic [31:0] rv);
    slot_t n;
    if (!rst_n || flush) begin
      n.data  = rv;
      n.valid = 1'b0;
    end else if (!en) begin
      n = cur;
    end else begin
      n.data  = d;
      n.valid = in_valid;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    exp32 = next_slot(exp32, in32, 32'h0);
    exp8  = next_slot(exp8, {24'h0, in8}, 32'h5A);
    if (!rst_n) known = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, half a period after each edge.
  always @(negedge clk) begin
    if (known) begin
      check("model_out32", out32, exp32.data);
      check("model_ov32", {31'h0, ov32}, {31'h0, exp32.valid});
      check("model_out8", {24'h0, out8}, exp8.data);
      check("model_ov8", {31'h0, ov8}, {31'h0, exp8.valid});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    rst_n = 1'b1; flush = 1'b0; en = 1'b1; in_valid = 1'b1;
    in32 = v; in8 = v[7:0];
    step();
    check("load_out32", out32, v);
  endtask

  logic [31:0] seq [5];

  initial begin
    seq[0] = 32'hA5A5A5A5; seq[1] = 32'h5A5A5A5A; seq[2] = 32'hFFFFFFFF;
    seq[3] = 32'h00000000; seq[4] = 32'h12345678;

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b1;
    in32 = 32'hFFFFFFFF; in8 = 8'hFF;
    #2;
    step();
    check("rst_out32", out32, 32'h0);
    check("rst_ov32", {31'h0, ov32}, 32'h0);
    check("rst_out8", {24'h0, out8}, 32'h5A);

    // Streaming: each value appears one edge later, in order.
    rst_n = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in32 = seq[i]; in8 = seq[i][7:0];
      step();
      check("stream_out32", out32, seq[i]);
      check("stream_ov32", {31'h0, ov32}, 32'h1);
      if (i == 0) check("w8_load_out8", {24'h0, out8}, 32'hA5);
    end

    // Reset from an all-ones word; no effect until the edge.
    load(32'hFFFFFFFF);
    rst_n = 1'b0;
    #3;
    check("rst_between_edges", out32, 32'hFFFFFFFF);
    step();
    check("rst2_out32", out32, 32'h0);
    check("rst2_ov32", {31'h0, ov32}, 32'h0);

    // Stall for three edges, then release.
    load(32'hA5A5A5A5);
    en = 1'b0; in32 = 32'h5A5A5A5A; in8 = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_out32", out32, 32'hA5A5A5A5);
    end
    en = 1'b1;
    step();
    check("unstall_out32", out32, 32'h5A5A5A5A);

    // Flush together with stall: flush wins.
    load(32'h12345678);
    flush = 1'b1; en = 1'b0;
    step();
    check("flush_out32", out32, 32'h0);
    check("flush_ov32", {31'h0, ov32}, 32'h0);
    check("flush_out8", {24'h0, out8}, 32'h5A);

    // Reset and flush together with all-ones input.
    load(32'hCAFEF00D);
    rst_n = 1'b0; flush = 1'b1; en = 1'b1; in32 = 32'hFFFFFFFF; in8 = 8'hFF;
    step();
    check("prio_out32", out32, 32'h0);
    check("prio_ov32", {31'h0, ov32}, 32'h0);

    // After release, nothing loads until en=1.
    rst_n = 1'b1; flush = 1'b0; en = 1'b0; in32 = 32'h0BADBEEF;
    step();
    check("post_rst_hold", out32, 32'h0);
    en = 1'b1; in_valid = 1'b0;
    step();
    check("post_rst_load", out32, 32'h0BADBEEF);
    check("load_invalid_ov", {31'h0, ov32}, 32'h0);

    // Randomized traffic, checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 15) != 0);
      flush    = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      in32     = $urandom;
      in8      = 8'($urandom);
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
